// File: rtl/io_port_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : io_port_responder_if
// Description : CPU <-> IO responder handshake bundle for IN/OUT instructions.
// Revision    : 1.0  initial release
// ============================================================================
interface io_port_responder_if;
    logic [1:0]  entradaSaidaControl;
    logic [31:0] dadosEscrita;
    logic [31:0] DadosLidos;
    logic        pausa;
    logic        pronto;
    logic        erro;

    modport master (
        output entradaSaidaControl,
        output dadosEscrita,
        input  DadosLidos,
        input  pausa,
        input  pronto,
        input  erro
    );

    modport slave (
        input  entradaSaidaControl,
        input  dadosEscrita,
        output DadosLidos,
        output pausa,
        output pronto,
        output erro
    );
endinterface
`default_nettype wire

// File: rtl/io_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : io_port_responder
// Description : Peripheral side of CPU IN/OUT: debounced button read and
//               sequential binary-to-BCD display. Optional IN timeout is
//               enabled by defining IO_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module io_port_responder #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd5000000
) (
    input  wire logic             clock,
    input  wire logic             reset,
    io_port_responder_if.slave    bus,
    input  wire logic [3:0]       entradaDeDados,
    input  wire logic             botaoIN,
    output logic [3:0]            unidade,
    output logic [3:0]            dezena,
    output logic [3:0]            centena
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_IN = 2'd1,
        S_CONV    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_BIT = 4'd9;

    // ---------------- button synchronizer / debouncer ----------------
    logic        r_btn_s1;
    logic        r_btn_s2;
    logic        r_btn_stable;
    logic        r_btn_prev;
    logic [15:0] r_db_cnt;
    logic        w_press;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_btn_s1     <= 1'b0;
            r_btn_s2     <= 1'b0;
            r_btn_stable <= 1'b0;
            r_btn_prev   <= 1'b0;
            r_db_cnt     <= 16'd0;
        end else begin
            r_btn_s1   <= botaoIN;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_stable;
            // Any return to the stable level restarts the qualification window
            if (r_btn_s2 != r_btn_stable) begin
                if (r_db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                    r_btn_stable <= r_btn_s2;
                    r_db_cnt     <= 16'd0;
                end else begin
                    r_db_cnt <= r_db_cnt + 16'd1;
                end
            end else begin
                r_db_cnt <= 16'd0;
            end
        end
    end

    assign w_press = r_btn_stable & ~r_btn_prev;

    // ---------------- request decode ----------------
    logic [1:0] w_ctrl_eff;
    logic [9:0] w_src;

    assign w_ctrl_eff = (bus.entradaSaidaControl == 2'b11) ? 2'b00 : bus.entradaSaidaControl;
    assign w_src      = (bus.dadosEscrita <= 32'd999) ? bus.dadosEscrita[9:0] : 10'd999;

    // ---------------- double-dabble step ----------------
    // Layout: [21:10] BCD digits (hundreds..units), [9:0] remaining binary bits
    function automatic logic [21:0] dabble_step(input logic [21:0] v);
        logic [21:0] t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            if (t[10 + 4*i +: 4] >= 4'd5) begin
                t[10 + 4*i +: 4] = t[10 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[20:0], 1'b0};
    endfunction

    logic [21:0] r_shift;
    logic [21:0] w_shift_next;

    assign w_shift_next = dabble_step(r_shift);

    // ---------------- control FSM ----------------
    state_t      r_state;
    logic [1:0]  r_ctrl_prev;
    logic [3:0]  r_bit_cnt;
    logic [31:0] r_dados_lidos;
    logic        r_pausa;
    logic        r_pronto;
    logic [3:0]  r_unidade;
    logic [3:0]  r_dezena;
    logic [3:0]  r_centena;
`ifdef IO_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_erro;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ctrl_prev   <= 2'b00;
            r_bit_cnt     <= 4'd0;
            r_shift       <= 22'd0;
            r_dados_lidos <= 32'd0;
            r_pausa       <= 1'b0;
            r_pronto      <= 1'b0;
            r_unidade     <= 4'd0;
            r_dezena      <= 4'd0;
            r_centena     <= 4'd0;
`ifdef IO_TIMEOUT_EN
            r_to_cnt      <= 32'd0;
            r_erro        <= 1'b0;
`endif
        end else begin
            r_ctrl_prev <= w_ctrl_eff;
            r_pronto    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Only a 00 -> request edge starts an operation
                    if (r_ctrl_prev == 2'b00) begin
                        if (w_ctrl_eff == 2'b01) begin
                            r_state  <= S_WAIT_IN;
                            r_pausa  <= 1'b1;
`ifdef IO_TIMEOUT_EN
                            r_to_cnt <= 32'd0;
`endif
                        end else if (w_ctrl_eff == 2'b10) begin
                            r_state   <= S_CONV;
                            r_pausa   <= 1'b1;
                            r_shift   <= {12'd0, w_src};
                            r_bit_cnt <= 4'd0;
                        end
                    end
                end
                S_WAIT_IN: begin
                    if (w_press) begin
                        r_dados_lidos <= {28'd0, entradaDeDados};
`ifdef IO_TIMEOUT_EN
                        r_erro        <= 1'b0;
`endif
                        r_state       <= S_DONE;
                        r_pausa       <= 1'b0;
                        r_pronto      <= 1'b1;
                    end
`ifdef IO_TIMEOUT_EN
                    else if (r_to_cnt == TIMEOUT_CYCLES - 32'd1) begin
                        r_dados_lidos <= 32'd0;
                        r_erro        <= 1'b1;
                        r_state       <= S_DONE;
                        r_pausa       <= 1'b0;
                        r_pronto      <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
`endif
                end
                S_CONV: begin
                    r_shift <= w_shift_next;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        r_centena <= w_shift_next[21:18];
                        r_dezena  <= w_shift_next[17:14];
                        r_unidade <= w_shift_next[13:10];
                        r_state   <= S_DONE;
                        r_pausa   <= 1'b0;
                        r_pronto  <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pausa <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DadosLidos = r_dados_lidos;
    assign bus.pausa      = r_pausa;
    assign bus.pronto     = r_pronto;
    assign unidade        = r_unidade;
    assign dezena         = r_dezena;
    assign centena        = r_centena;

`ifdef IO_TIMEOUT_EN
    assign bus.erro = r_erro;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign bus.erro         = 1'b0;
`endif

endmodule
`default_nettype wire
